// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and exception kill.
// Optional PIPE_STAGE_STATS_EN adds saturating stall/bubble cycle counters.
module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int EXC_W  = 5
) (
`ifdef PIPE_STAGE_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d, in_entry;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   accept;

    // An excepting entry must never write architectural state downstream.
    always_comb begin
        in_entry.data = in_data;
        in_entry.ctrl = (in_exc != '0) ? '0 : in_ctrl;
        in_entry.exc  = in_exc;
        in_entry.bd   = in_bd;
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_entry;
                end
            end else begin
                main_d       = in_entry;
                main_valid_d = accept;
            end
        end else if (accept) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_q.data;
    assign out_ctrl  = main_valid_q ? main_q.ctrl : '0;
    assign out_exc   = main_q.exc;
    assign out_bd    = main_q.bd;

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (main_valid_q && !out_ready) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (!main_valid_q) begin
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, hand sequences, and random traffic vs a FIFO model.
// Define PIPE_STAGE_STATS_EN to also exercise the stall/bubble counters.
module tb_pipe_stage_skid;
    localparam int DATA_W = 128;
    localparam int CTRL_W = 8;
    localparam int EXC_W  = 5;

    logic              CLK = 1'b0;
    logic              reset_n = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [EXC_W-1:0]  in_exc = '0;
    logic              in_bd = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [EXC_W-1:0]  out_exc;
    logic              out_bd;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .EXC_W(EXC_W)) dut (
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .CLK      (CLK),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_exc   (in_exc),
        .in_bd    (in_bd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_exc  (out_exc),
        .out_bd   (out_bd)
    );

    typedef struct {
        logic              iv, ordy, fl;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic [EXC_W-1:0]  e;
        logic              b;
        logic              ev, er;
        logic [DATA_W-1:0] ed;
        logic [CTRL_W-1:0] ec;
        logic [EXC_W-1:0]  ee;
        logic              eb;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic [EXC_W-1:0]  e;
        logic              b;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic void add(input int iv, input int ordy, input int fl, input int d, input int c,
                                input int e, input int b, input int ev, input int er, input int ed,
                                input int ec, input int ee, input int eb);
        vec_t v;
        v.iv = iv[0]; v.ordy = ordy[0]; v.fl = fl[0];
        v.d = DATA_W'(d); v.c = CTRL_W'(c); v.e = EXC_W'(e); v.b = b[0];
        v.ev = ev[0]; v.er = er[0];
        v.ed = DATA_W'(ed); v.ec = CTRL_W'(ec); v.ee = EXC_W'(ee); v.eb = eb[0];
        vecs.push_back(v);
    endfunction

    initial begin
        int          n;
        bit          acc;
        ent_t        en;
        int unsigned m_stall, m_bubble;

        // Vector table: inputs applied for one edge, expected outputs after that edge.
        add(1,1,0,'hA5,'h03,0,0, 1,1,'hA5,'h03,0,0);
        for (int k = 1; k <= 8; k++) add(1,1,0,k,'h01,0,0, 1,1,k,'h01,0,0);
        add(0,1,0,0,0,0,0,     0,1,0,0,0,0);
        add(1,0,0,'h11,'h02,0,0, 1,1,'h11,'h02,0,0);
        add(1,0,0,'h22,'h02,0,0, 1,0,'h11,'h02,0,0);
        add(1,0,0,'h33,'h02,0,0, 1,0,'h11,'h02,0,0);
        add(1,1,0,'h33,'h02,0,0, 1,1,'h22,'h02,0,0);
        add(1,1,0,'h33,'h02,0,0, 1,1,'h33,'h02,0,0);
        add(0,1,0,0,0,0,0,     0,1,0,0,0,0);
        add(1,0,0,'h44,'h04,0,0, 1,1,'h44,'h04,0,0);
        add(1,0,0,'h55,'h04,0,0, 1,0,'h44,'h04,0,0);
        add(1,0,1,'h66,'h04,0,0, 0,1,0,0,0,0);
        add(1,1,1,'h66,'h04,0,0, 0,1,0,0,0,0);
        add(0,1,0,0,0,0,0,     0,1,0,0,0,0);
        add(1,1,0,'h88,'hFF,4,1, 1,1,'h88,'h00,4,1);
        add(1,1,0,'h99,'hFF,0,0, 1,1,'h99,'hFF,0,0);
        add(0,1,0,0,0,0,0,     0,1,0,0,0,0);

        // Reset held with an offered entry.
        #2 reset_n = 1'b0;
        in_valid = 1'b1; in_data = DATA_W'(32'hA5); in_ctrl = 8'h03; out_ready = 1'b1;
        tick(); tick();
        chk("rst_out_valid", DATA_W'(out_valid), DATA_W'(1'b0));
        chk("rst_out_ctrl",  DATA_W'(out_ctrl),  DATA_W'(1'b0));
        chk("rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1'b1));
        chk("rst_out_data",  out_data,           '0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; out_ready = vecs[i].ordy; flush = vecs[i].fl;
            in_data = vecs[i].d; in_ctrl = vecs[i].c; in_exc = vecs[i].e; in_bd = vecs[i].b;
            tick();
            chk($sformatf("v%0d_out_valid", i), DATA_W'(out_valid), DATA_W'(vecs[i].ev));
            chk($sformatf("v%0d_in_ready", i),  DATA_W'(in_ready),  DATA_W'(vecs[i].er));
            chk($sformatf("v%0d_out_ctrl", i),  DATA_W'(out_ctrl),  DATA_W'(vecs[i].ec));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_out_data", i), out_data, vecs[i].ed);
                chk($sformatf("v%0d_out_exc", i),  DATA_W'(out_exc), DATA_W'(vecs[i].ee));
                chk($sformatf("v%0d_out_bd", i),   DATA_W'(out_bd),  DATA_W'(vecs[i].eb));
            end
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a cycle clears without a clock edge.
        in_valid = 1'b1; in_data = DATA_W'(32'hBB); in_ctrl = 8'h07; in_exc = '0; out_ready = 1'b0;
        tick();
        chk("async_pre_valid", DATA_W'(out_valid), DATA_W'(1'b1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_out_valid", DATA_W'(out_valid), DATA_W'(1'b0));
        chk("async_out_data",  out_data,           '0);
        chk("async_in_ready",  DATA_W'(in_ready),  DATA_W'(1'b1));
        in_valid = 1'b0;
        tick();
        reset_n = 1'b1;

`ifdef PIPE_STAGE_STATS_EN
        // One bubble while the first entry loads, 3 stalls, drain, one more bubble.
        reset_n = 1'b0; #1;
        in_valid = 1'b1; in_data = DATA_W'(32'hC1); in_ctrl = 8'h01; out_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        out_ready = 1'b1;
        tick(); tick();
        chk("stats_stall",  DATA_W'(stall_cnt),  DATA_W'(32'd3));
        chk("stats_bubble", DATA_W'(bubble_cnt), DATA_W'(32'd2));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("stats_flush_stall",  DATA_W'(stall_cnt),  '0);
        chk("stats_flush_bubble", DATA_W'(bubble_cnt), '0);
`endif

        // Random traffic against a 2-deep FIFO model of the stage.
        reset_n = 1'b0; #1;
        in_valid = 1'b0; flush = 1'b0;
        tick();
        reset_n = 1'b1;
        mq.delete();
        m_stall = 0; m_bubble = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_data   = DATA_W'({$urandom, $urandom, $urandom, $urandom});
            in_ctrl   = CTRL_W'($urandom);
            in_exc    = ($urandom_range(0, 3) == 0) ? EXC_W'($urandom) : '0;
            in_bd     = $urandom_range(0, 1) == 1;

            n   = mq.size();
            acc = in_valid && (n < 2);
            if (flush) begin
                mq.delete();
                m_stall = 0; m_bubble = 0;
            end else begin
                if (n > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
                if (n == 0 && m_bubble != 32'hFFFF_FFFF) m_bubble++;
                if (n > 0 && out_ready) void'(mq.pop_front());
                if (acc) begin
                    en.d = in_data;
                    en.c = (in_exc != 0) ? '0 : in_ctrl;
                    en.e = in_exc;
                    en.b = in_bd;
                    mq.push_back(en);
                end
            end

            tick();
            chk($sformatf("r%0d_out_valid", cyc), DATA_W'(out_valid), DATA_W'(mq.size() > 0));
            chk($sformatf("r%0d_in_ready", cyc),  DATA_W'(in_ready),  DATA_W'(mq.size() < 2));
            if (mq.size() > 0) begin
                chk($sformatf("r%0d_out_ctrl", cyc), DATA_W'(out_ctrl), DATA_W'(mq[0].c));
                chk($sformatf("r%0d_out_data", cyc), out_data,          mq[0].d);
                chk($sformatf("r%0d_out_exc", cyc),  DATA_W'(out_exc),  DATA_W'(mq[0].e));
                chk($sformatf("r%0d_out_bd", cyc),   DATA_W'(out_bd),   DATA_W'(mq[0].b));
            end else begin
                chk($sformatf("r%0d_out_ctrl", cyc), DATA_W'(out_ctrl), '0);
            end
`ifdef PIPE_STAGE_STATS_EN
            chk($sformatf("r%0d_stall", cyc),  DATA_W'(stall_cnt),  DATA_W'(m_stall));
            chk($sformatf("r%0d_bubble", cyc), DATA_W'(bubble_cnt), DATA_W'(m_bubble));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed EX/MEM-style stage register.
- Same pipeline-stage role, adding a valid/ready handshake with a 2-entry skid buffer, synchronous flush and exception-kill of control bits.
- Sits between any two pipeline stages (EX->MEM, MEM->WB) so stalls propagate without combinational ready paths upstream.

Parameters:
DATA_W, 128, payload width (IR, PC+4, ALU out, store data, register addresses, concatenated by the instantiator)
CTRL_W, 8, control-bit width (RegWrite, MemtoReg, MemWrite, Link, CP0WE, ...)
EXC_W, 5, exception-code width; 0 = no exception

Ports:
CLK  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  payload
in_ctrl  in  CTRL_W  control bits
in_exc  in  EXC_W  exception code
in_bd  in  1  entry is in a branch delay slot
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts main entry
out_data  out  DATA_W  main payload
out_ctrl  out  CTRL_W  main control bits, gated
out_exc  out  EXC_W  main exception code
out_bd  out  1  main delay-slot flag

Behaviour:
- Clock and reset: one clock CLK; reset_n is asynchronous, active-low.
- Storage: main register (drives outputs) and skid register, each with a valid bit.
- in_ready = !skid_valid. It is a registered value only, with no combinational path from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Reset (reset_n=0, async): main_valid=0, skid_valid=0, all data/ctrl/exc/bd regs=0. Hence out_valid=0, out_*=0, in_ready=1.
- Priority per edge: reset > flush > normal.
- flush=1: main_valid<=0, skid_valid<=0. The entry accepted that cycle is dropped. Data regs may hold stale values.
- Normal, main empty or draining:
  - skid_valid=1: main<=skid, skid_valid<=Accept (skid<=input if Accept).
  - skid_valid=0: main<=input, main_valid<=Accept.
- Normal, main full and not draining:
  - Accept=1: skid<=input, skid_valid<=1.
  - else hold.
- Latency: 1 cycle input->output when empty; throughput 1 entry/cycle sustained.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush.
- Exception kill: an entry with in_exc != 0 is stored with ctrl forced to 0. exc and bd are stored as given.
- out_ctrl = main_ctrl when out_valid, else 0 (bubble never writes). out_data/out_exc/out_bd show the main regs unchanged.
- Boundaries:
  - Both entries full: in_ready=0; upstream must hold.
  - out_ready=1 with skid full: skid moves to main; in_ready rises next cycle.
  - Flush with both full: both dropped in one edge.
  - reset_n asserted mid-transfer clears immediately, without waiting for CLK.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined:
  - Adds out port stall_cnt (32) counting cycles with out_valid=1 & out_ready=0.
  - Adds out port bubble_cnt (32) counting cycles with out_valid=0.
  - Both counters reset to 0 by reset_n and by flush, and saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, in_data=0xA5 -> out_valid=0, out_ctrl=0, in_ready=1. Deassert, then one edge with in_valid=1 -> out_valid=1, out_data=0xA5.
- Streaming: out_ready=1, send data 1..8 back-to-back -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Backpressure: out_ready=0, send 0x11, 0x22, 0x33 -> main=0x11, skid=0x22, in_ready=0, 0x33 held. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order.
- Flush with main and skid full: flush=1 -> next cycle out_valid=0, in_ready=1, out_ctrl=0; entry offered during flush never appears.
- Exception kill: in_ctrl=0xFF, in_exc=5'd4, in_bd=1 -> out_ctrl=0x00, out_exc=4, out_bd=1. Same ctrl with in_exc=0 -> out_ctrl=0xFF.
- PIPE_STAGE_STATS_EN: 3 stall cycles then 2 empty cycles -> stall_cnt=3, bubble_cnt=2. Then flush -> both counters 0.
